// File: rtl/s_mem_reader.sv
// s_mem_reader: streams all 256 bytes of a read-only S-memory out over a valid/ready
// handshake, checking each byte against its own address and keeping mismatch statistics.
`default_nettype none

module s_mem_reader #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_flag,
  output logic [7:0] address,
  output logic       wren,
  input  logic [7:0] q,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done_flag,
  output logic       mismatch_flag,
  output logic [7:0] mismatch_addr,
  output logic [8:0] mismatch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] c_WAIT_LAST = 2'(READ_LATENCY);

  state_t     r_state;
  logic       r_start_prev;
  logic       r_start_armed;
  logic [1:0] r_wait;
  logic       w_start_edge;
  logic       w_byte_diff;

  // A start edge only counts once start_flag has been seen low since reset,
  // so a request held high across reset release cannot launch a run.
  assign w_start_edge = start_flag & ~r_start_prev & r_start_armed;
  assign w_byte_diff  = (q != address);
  assign wren         = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_start_prev   <= 1'b0;
      r_start_armed  <= 1'b0;
      r_wait         <= 2'd0;
      address        <= 8'd0;
      out_data       <= 8'd0;
      out_valid      <= 1'b0;
      done_flag      <= 1'b0;
      mismatch_flag  <= 1'b0;
      mismatch_addr  <= 8'd0;
      mismatch_count <= 9'd0;
    end else begin
      r_start_prev <= start_flag;
      if (!start_flag) begin
        r_start_armed <= 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_edge) begin
            r_state        <= S_READ;
            r_wait         <= 2'd0;
            address        <= 8'd0;
            done_flag      <= 1'b0;
            mismatch_flag  <= 1'b0;
            mismatch_addr  <= 8'd0;
            mismatch_count <= 9'd0;
          end
        end

        S_READ: begin
          // Address is held READ_LATENCY+1 cycles; q is sampled on the last one.
          if (r_wait == c_WAIT_LAST) begin
            out_data  <= q;
            out_valid <= 1'b1;
            r_state   <= S_OUT;
            if (w_byte_diff) begin
              mismatch_count <= mismatch_count + 9'd1;
              if (!mismatch_flag) begin
                mismatch_flag <= 1'b1;
                mismatch_addr <= address;
              end
            end
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (address != 8'd255) begin
              address <= address + 8'd1;
              r_wait  <= 2'd0;
              r_state <= S_READ;
            end else begin
              done_flag <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/s_mem_reader.md
S_MEM_READER -- requirements
Module: s_mem_reader

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, meaning cycles from the RAM latching an address to q being valid; legal values are 1 and 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_flag, input, 1, run request; a rising edge starts a run.
REQ-005 SHALL have port address, output, 8, read address to the 256x8 S-memory.
REQ-006 SHALL have port wren, output, 1, memory write enable; tied 0 (read-only block).
REQ-007 SHALL have port q, input, 8, read data from the S-memory.
REQ-008 SHALL have port out_data, output, 8, byte read from the current address.
REQ-009 SHALL have port out_valid, output, 1, out_data valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-011 SHALL have port done_flag, output, 1, all 256 bytes transferred.
REQ-012 SHALL have port mismatch_flag, output, 1, sticky: some byte differed from its address.
REQ-013 SHALL have port mismatch_addr, output, 8, first address whose byte differed.
REQ-014 SHALL have port mismatch_count, output, 9, number of differing bytes (0..256).

Function
REQ-015 SHALL register start_flag and detect a rising edge as start_flag==1 with the previous sample ==0.
REQ-016 SHALL implement states IDLE, READ, OUT, DONE.
REQ-017 IDLE or DONE, start edge at edge k -> READ at edge k, address=0, done_flag=0, mismatch_flag/addr/count cleared.
REQ-018 READ: hold address for READ_LATENCY+1 cycles, then on that edge capture q into out_data, set out_valid=1, go to OUT.
REQ-019 Capture edge SHALL compare q with address; on difference increment mismatch_count and, if mismatch_flag==0, set mismatch_flag=1 and mismatch_addr=address.
REQ-020 OUT: out_data and out_valid SHALL stay stable while out_ready==0; no timeout.
REQ-021 OUT with out_ready==1 at an edge: handshake; out_valid=0; if address<255 then address+1 and go to READ, else go to DONE with done_flag=1.
REQ-022 Address SHALL never wrap; the run ends after address 255 is transferred.
REQ-023 out_ready SHALL be ignored outside OUT; start edges SHALL be ignored in READ and OUT.
REQ-024 DONE: done_flag, mismatch outputs and last out_data SHALL hold until a new start edge or reset.
REQ-025 Per-byte cost SHALL be READ_LATENCY+2 cycles with out_ready held 1; first out_valid rises at edge k+READ_LATENCY+1.
REQ-026 wren SHALL be 0 in every state and during reset.

Reset
REQ-027 reset_n==0 SHALL immediately force IDLE, address=0, out_data=0, out_valid=0, done_flag=0, mismatch_flag=0, mismatch_addr=0, mismatch_count=0, wren=0, start-edge register=0.
REQ-028 Reset mid-run SHALL abandon the run; after release, no read occurs until a new start edge (start_flag held 1 through release does not start a run).

Verification
REQ-029 Identity memory (S[i]=i), READ_LATENCY=1, out_ready=1, start edge at edge k -> 256 bytes 0..255 in order, done_flag=1 at edge k+768, mismatch_flag=0, mismatch_count=0.
REQ-030 Memory with S[5]=0xAA and S[200]=0x00 -> mismatch_flag=1, mismatch_addr=5, mismatch_count=2, done_flag=1.
REQ-031 out_ready low for 10 cycles while out_valid is high at address 3 -> out_data=3 held, address unchanged, no byte lost or duplicated.
REQ-032 READ_LATENCY=2, identity memory, out_ready=1 -> first out_valid at edge k+3, done_flag at edge k+1024.
REQ-033 reset_n pulsed low during byte 100 with start_flag held 1 -> all outputs reset; no run until start_flag goes 0 then 1; new run restarts at address 0 with cleared mismatch stats.
REQ-034 Second start edge mid-run and after DONE -> ignored mid-run; after DONE it restarts at address 0 with done_flag cleared.
